cfu_bus_bridge: RTL and testbench
=================================

# cfu_bus_bridge

Initiator-side bridge between the CPU's CFU bus (valid/ready command and response channels) and the `en`/`cmd`/`inp0`/`inp1`/`ret`/`output_buffer_valid` port set of our CFU datapath modules.

- Accepts one instruction at a time and issues it to the CFU as a single-cycle `en` pulse.
- Waits for `output_buffer_valid`, then holds the result on the response channel until the CPU takes it.
- Times out hung operations.
- Answers a local status instruction without touching the CFU.

## Interface

Parameters:

- `INT32_SIZE`, default 32: data width of operands and result.
- `CMD_SIZE`, default 7: width of the CFU `cmd` field.
- `TIMEOUT`, default 255: maximum WAIT cycles before an operation is abandoned.
- `TIMEOUT_WORD`, default 32'hDEAD_BEEF: result returned when an operation times out.

Ports:

- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  CPU command valid.
- `cmd_ready`  out  1  bridge can accept a command.
- `cmd_payload_function_id`  in  10  {funct7, funct3}.
- `cmd_payload_inputs_0`  in  INT32_SIZE  rs1 operand.
- `cmd_payload_inputs_1`  in  INT32_SIZE  rs2 operand.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  CPU accepts response.
- `rsp_payload_outputs_0`  out  INT32_SIZE  result.
- `cfu_en`  out  1  one-cycle issue strobe to the CFU.
- `cfu_cmd`  out  CMD_SIZE  funct7 of the latched command.
- `cfu_inp0`  out  INT32_SIZE  latched rs1.
- `cfu_inp1`  out  INT32_SIZE  latched rs2.
- `cfu_ret`  in  INT32_SIZE  CFU result.
- `cfu_output_buffer_valid`  in  1  CFU result valid.
- `busy`  out  1  high in any state other than IDLE.

## Operation

FSM states are IDLE, ISSUE, WAIT and RESP. The state resets to IDLE.

- **IDLE**
  - `cmd_ready = reset_n`, combinational on state IDLE; it is 0 in every other state.
  - On `cmd_valid`, latch the operands, `funct7` and `funct3`.
  - If `funct3 == 3'b111` (local), load the response register with the status word and go to RESP.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `cfu_en = 1` for exactly this cycle.
  - `cfu_cmd`/`cfu_inp0`/`cfu_inp1` show the latched values; they are held until the next accept.
  - Always go to WAIT.
- **WAIT**
  - Each cycle, if `cfu_output_buffer_valid`: capture `cfu_ret`, increment `op_count`, go to RESP.
  - Otherwise increment `wait_cnt`.
  - When `wait_cnt == TIMEOUT` with valid still low: load `TIMEOUT_WORD`, increment `timeout_count`, go to RESP.
  - If valid arrives on the same cycle the timeout would fire, valid wins.
- **RESP**
  - `rsp_valid = 1`; the data is stable while `rsp_ready` is low.
  - On `rsp_ready`, go to IDLE.

Status word and local commands:

- Status word is `{timeout_count[15:0], op_count[15:0]}`. Both counters are 16-bit and saturate at 16'hFFFF (no wrap).
- Local command with `funct7 == 0`: read only.
- Local command with `funct7 == 1`: read, then clear both counters. The pre-clear value is returned.
- Local command with any other `funct7`: treated as a read.
- Local commands never assert `cfu_en` and never count in `op_count`.

## Timing

- Reset (`reset_n` low, asynchronous):
  - state IDLE.
  - `cfu_en`, `rsp_valid`, `busy` and `cmd_ready` are 0.
  - `cfu_cmd`, `cfu_inp0`, `cfu_inp1`, `rsp_payload_outputs_0`, both counters and `wait_cnt` are 0.
- Reset mid-operation abandons the transaction. No response is produced, and the CFU sees no further `en`.
- CFU-op latency:
  - Cycle 0: accept.
  - Cycle 1: `cfu_en`.
  - Cycle 2: earliest capture (`cfu_output_buffer_valid` sampled in WAIT).
  - Cycle 3: earliest `rsp_valid`.
- Local-op latency: accept at cycle 0, `rsp_valid` at cycle 1.
- After `rsp_ready`, the next accept is possible 1 cycle later.
- Only one transaction is in flight. `cfu_output_buffer_valid` is ignored outside WAIT.
- `wait_cnt` is $clog2(TIMEOUT+1) bits wide and is cleared on entry to WAIT.

## Structure

- Package `cfu_bridge_pkg` holds:
  - the state enum;
  - `LOCAL_FUNCT3 = 3'b111`;
  - local funct7 codes `STAT_READ = 0` and `STAT_CLEAR = 1`;
  - the status-word field offsets.
- Sub-module `sat_counter16`: 16-bit saturating counter with `inc`, `clr`, `clk`, `reset_n` and `q`. It is instantiated twice.
- The FSM, operand latches and response register live in the top.

## Test plan

- **Basic op:** `function_id = {7'd5, 3'd0}`, inputs 3 and 4; CFU model returns 32'h7 with valid on its first WAIT cycle.
  - Required: `cfu_en` high exactly 1 cycle with `cfu_cmd = 5`.
  - Required: `rsp_valid` at cycle 3 with data 7.
  - Required: `op_count = 1`.
- **Backpressure:** hold `rsp_ready` low for 10 cycles.
  - Required: `rsp_valid` and data stable for all 10 cycles.
  - Required: `cmd_ready` stays 0 throughout.
  - Required: IDLE 1 cycle after `rsp_ready`.
- **Timeout:** with `TIMEOUT = 4`, CFU valid is never raised.
  - Required: response 32'hDEAD_BEEF after 4 WAIT cycles.
  - Required: status read returns 32'h0001_0000.
  - Second case: valid raised exactly on WAIT cycle 4. Required: the real result is returned and `timeout_count` is unchanged.
- **Local clear:** after 3 ops, send `{7'd1, 3'b111}`.
  - Required: response 32'h0000_0003 at cycle 1, with no `cfu_en`.
  - Required: a following read returns 0.
- **Saturation:** force `op_count = 16'hFFFE` and run 3 ops. Required: status reads 32'h0000_FFFF.
- **Reset mid-WAIT:** pulse `reset_n` low.
  - Required: all outputs 0 immediately (asynchronous), with no `rsp_valid`.
  - Required: `cmd_ready = 1` on the first cycle after release.

Source files
------------

// File: rtl/cfu_bridge_pkg.sv
// Shared types and constants for the CFU bus bridge.
// Holds the FSM state encoding, local-instruction decode codes and status-word layout.
// No logic of its own; the status_word helper is purely combinational.
package cfu_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // funct3 value that marks an instruction answered by the bridge itself
    localparam logic [2:0] LOCAL_FUNCT3 = 3'b111;

    // funct7 codes for local instructions; anything else behaves as a read
    localparam logic [6:0] STAT_READ  = 7'd0;
    localparam logic [6:0] STAT_CLEAR = 7'd1;

    // Status word field offsets: {timeout_count, op_count}
    localparam int STAT_OPS_LSB = 0;
    localparam int STAT_TO_LSB  = 16;

    function automatic logic [31:0] status_word(input logic [15:0] to_cnt,
                                                input logic [15:0] op_cnt);
        return (32'(to_cnt) << STAT_TO_LSB) | (32'(op_cnt) << STAT_OPS_LSB);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
// Latency: q reflects an inc/clr one cycle after it is sampled.
// No backpressure; clr has priority over inc.
module sat_counter16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // Count up on inc, hold at all-ones, clear on request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 16'd0;
        end else if (clr) begin
            r_q <= 16'd0;
        end else if (inc && (r_q != 16'hFFFF)) begin
            r_q <= r_q + 16'd1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/cfu_bus_bridge.sv
// Bridges the CPU CFU command/response channels onto a CFU en/cmd/inp/ret port set.
// Latency: CFU op accept->rsp_valid >= 3 cycles; local status op accept->rsp_valid 1 cycle.
// One transaction in flight: cmd_ready only in IDLE; the response is held until rsp_ready.
module cfu_bus_bridge
    import cfu_bridge_pkg::*;
#(
    parameter int                    INT32_SIZE   = 32,
    parameter int                    CMD_SIZE     = 7,
    parameter int                    TIMEOUT      = 255,
    parameter logic [INT32_SIZE-1:0] TIMEOUT_WORD = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [9:0]            cmd_payload_function_id,
    input  logic [INT32_SIZE-1:0] cmd_payload_inputs_0,
    input  logic [INT32_SIZE-1:0] cmd_payload_inputs_1,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [INT32_SIZE-1:0] rsp_payload_outputs_0,
    output logic                  cfu_en,
    output logic [CMD_SIZE-1:0]   cfu_cmd,
    output logic [INT32_SIZE-1:0] cfu_inp0,
    output logic [INT32_SIZE-1:0] cfu_inp1,
    input  logic [INT32_SIZE-1:0] cfu_ret,
    input  logic                  cfu_output_buffer_valid,
    output logic                  busy
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    state_t                r_state;
    logic                  r_cfu_en;
    logic                  r_rsp_vld;
    logic [CMD_SIZE-1:0]   r_cmd;
    logic [INT32_SIZE-1:0] r_inp0;
    logic [INT32_SIZE-1:0] r_inp1;
    logic [INT32_SIZE-1:0] r_rsp_dat;
    logic [WCW-1:0]        r_wait_cnt;

    logic [6:0]     w_fn7;
    logic [2:0]     w_fn3;
    logic           w_accept;
    logic           w_local;
    logic           w_stat_clr;
    logic           w_op_inc;
    logic           w_to_inc;
    logic [WCW-1:0] w_wait_nxt;
    logic [15:0]    w_op_q;
    logic [15:0]    w_to_q;

    assign w_fn7      = cmd_payload_function_id[9:3];
    assign w_fn3      = cmd_payload_function_id[2:0];
    assign w_accept   = (r_state == S_IDLE) && cmd_valid;
    assign w_local    = (w_fn3 == LOCAL_FUNCT3);
    // Only STAT_CLEAR clears; STAT_READ and every other funct7 just read
    assign w_stat_clr = w_accept && w_local && (w_fn7 == STAT_CLEAR);
    assign w_wait_nxt = r_wait_cnt + WCW'(1);
    // A CFU result wins over a timeout firing in the same cycle
    assign w_op_inc   = (r_state == S_WAIT) && cfu_output_buffer_valid;
    assign w_to_inc   = (r_state == S_WAIT) && !cfu_output_buffer_valid
                        && (w_wait_nxt == WCW'(TIMEOUT));

    // cmd_ready is forced low while reset is asserted, independent of the clock
    assign cmd_ready             = reset_n && (r_state == S_IDLE);
    assign busy                  = (r_state != S_IDLE);
    assign rsp_valid             = r_rsp_vld;
    assign rsp_payload_outputs_0 = r_rsp_dat;
    assign cfu_en                = r_cfu_en;
    assign cfu_cmd               = r_cmd;
    assign cfu_inp0              = r_inp0;
    assign cfu_inp1              = r_inp1;

    sat_counter16 u_op_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_op_inc),
        .clr     (w_stat_clr),
        .q       (w_op_q)
    );

    sat_counter16 u_to_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_to_inc),
        .clr     (w_stat_clr),
        .q       (w_to_q)
    );

    // Transaction FSM with operand latches, registered strobes and response register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cfu_en   <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_cmd      <= '0;
            r_inp0     <= '0;
            r_inp1     <= '0;
            r_rsp_dat  <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_cfu_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd  <= CMD_SIZE'(w_fn7);
                        r_inp0 <= cmd_payload_inputs_0;
                        r_inp1 <= cmd_payload_inputs_1;
                        if (w_local) begin
                            // Counters are read before any clear lands
                            r_rsp_dat <= INT32_SIZE'(status_word(w_to_q, w_op_q));
                            r_rsp_vld <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            r_cfu_en <= 1'b1;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_op_inc) begin
                        r_rsp_dat <= cfu_ret;
                        r_rsp_vld <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_wait_cnt <= w_wait_nxt;
                        if (w_to_inc) begin
                            r_rsp_dat <= TIMEOUT_WORD;
                            r_rsp_vld <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_vld <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfu_bus_bridge.sv
// Directed bench for cfu_bus_bridge with a transaction-level expectation model.
// Expected outputs per cycle come from the documented latency table and counter rules.
// A single negedge compare process checks every DUT output against those expectations.
module tb_cfu_bus_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic        cfu_en;
    logic [6:0]  cfu_cmd;
    logic [31:0] cfu_inp0;
    logic [31:0] cfu_inp1;
    logic [31:0] cfu_ret;
    logic        cfu_output_buffer_valid;
    logic        busy;

    always #5 clk = ~clk;

    cfu_bus_bridge #(.TIMEOUT(TO)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .cfu_en                  (cfu_en),
        .cfu_cmd                 (cfu_cmd),
        .cfu_inp0                (cfu_inp0),
        .cfu_inp1                (cfu_inp1),
        .cfu_ret                 (cfu_ret),
        .cfu_output_buffer_valid (cfu_output_buffer_valid),
        .busy                    (busy)
    );

    // Expected outputs for the current cycle
    logic        chk_en;
    logic        e_cmd_ready, e_busy, e_cfu_en, e_rsp_valid;
    logic [6:0]  e_cmd;
    logic [31:0] e_inp0, e_inp1, e_rsp;

    // Model counters (saturating at 65535)
    int unsigned m_ops, m_tos;

    int n_vec = 0;
    int n_err = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check1("cmd_ready", cmd_ready, e_cmd_ready);
            check1("busy", busy, e_busy);
            check1("cfu_en", cfu_en, e_cfu_en);
            check1("rsp_valid", rsp_valid, e_rsp_valid);
            check32("cfu_cmd", {25'd0, cfu_cmd}, {25'd0, e_cmd});
            check32("cfu_inp0", cfu_inp0, e_inp0);
            check32("cfu_inp1", cfu_inp1, e_inp1);
            if (e_rsp_valid) check32("rsp_data", rsp_payload_outputs_0, e_rsp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        e_cmd_ready = 1'b1;
        e_busy      = 1'b0;
        e_cfu_en    = 1'b0;
        e_rsp_valid = 1'b0;
    endtask

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= 32'd65535) ? 32'd65535 : v + 32'd1;
    endfunction

    // One full transaction. vwait: WAIT cycle (1-based) on which the CFU raises
    // valid, 0 = never. hold: cycles rsp_ready stays low once the response is up.
    task automatic run_op(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ret, input int vwait, input int hold,
                          output logic [31:0] got);
        logic        is_local;
        logic [31:0] exp;
        // cycle 0: offer the command in IDLE
        exp_idle();
        cmd_valid = 1'b1;
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0 = a;
        cmd_payload_inputs_1 = b;
        cfu_output_buffer_valid = 1'b0;
        rsp_ready = 1'b0;
        is_local = (fid[2:0] == 3'b111);
        exp = 32'd0;
        if (is_local) begin
            exp = {m_tos[15:0], m_ops[15:0]};
            if (fid[9:3] == 7'd1) begin
                m_ops = 0;
                m_tos = 0;
            end
        end
        step();
        // operands are latched at accept; scramble the bus to prove it
        e_cmd  = fid[9:3];
        e_inp0 = a;
        e_inp1 = b;
        cmd_valid = 1'b0;
        cmd_payload_function_id = ~fid;
        cmd_payload_inputs_0 = ~a;
        cmd_payload_inputs_1 = ~b;
        e_cmd_ready = 1'b0;
        e_busy = 1'b1;
        if (!is_local) begin
            // issue cycle: en pulse; a stray CFU valid here must be ignored
            e_cfu_en = 1'b1;
            cfu_output_buffer_valid = 1'b1;
            cfu_ret = 32'hBAD0_0000;
            step();
            e_cfu_en = 1'b0;
            for (int k = 1; k <= TO; k++) begin
                cfu_output_buffer_valid = (k == vwait);
                cfu_ret = (k == vwait) ? ret : 32'hBAD0_0001;
                step();
                if (k == vwait) break;
            end
            if (vwait >= 1 && vwait <= TO) begin
                exp = ret;
                m_ops = sat_inc(m_ops);
            end else begin
                exp = 32'hDEAD_BEEF;
                m_tos = sat_inc(m_tos);
            end
        end
        // response cycles: CFU chatter and a pending command must not disturb it
        e_rsp_valid = 1'b1;
        e_rsp = exp;
        cfu_output_buffer_valid = 1'b1;
        cfu_ret = 32'hBAD0_0002;
        @(negedge clk);
        got = rsp_payload_outputs_0;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cfu_output_buffer_valid = 1'b0;
        exp_idle();
    endtask

    logic [31:0] got;

    initial begin
        chk_en = 1'b0;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_payload_function_id = 10'd0;
        cmd_payload_inputs_0 = 32'd0;
        cmd_payload_inputs_1 = 32'd0;
        rsp_ready = 1'b0;
        cfu_ret = 32'd0;
        cfu_output_buffer_valid = 1'b0;
        e_cmd_ready = 1'b0; e_busy = 1'b0; e_cfu_en = 1'b0; e_rsp_valid = 1'b0;
        e_cmd = 7'd0; e_inp0 = 32'd0; e_inp1 = 32'd0; e_rsp = 32'd0;
        m_ops = 0; m_tos = 0;
        chk_en = 1'b1;
        step();
        check32("reset_rsp_data", rsp_payload_outputs_0, 32'd0);
        step();
        reset_n = 1'b1;
        exp_idle();
        step();

        // basic op, then status read shows one op
        run_op({7'd5, 3'd0}, 32'd3, 32'd4, 32'h7, 1, 0, got);
        check32("basic_data", got, 32'h0000_0007);
        run_op({7'd0, 3'b111}, 32'd0, 32'd0, 32'd0, 0, 0, got);
        check32("basic_opcount", got, 32'h0000_0001);

        // backpressure: 10 cycles with rsp_ready low
        run_op({7'd6, 3'd1}, 32'd10, 32'd20, 32'h1234_5678, 1, 10, got);
        check32("bp_data", got, 32'h1234_5678);

        // third op, then clear returns the pre-clear count
        run_op({7'd7, 3'd3}, 32'd1, 32'd2, 32'hCAFE_0003, 2, 0, got);
        run_op({7'd1, 3'b111}, 32'd0, 32'd0, 32'd0, 0, 0, got);
        check32("clear_ret", got, 32'h0000_0003);
        run_op({7'd0, 3'b111}, 32'd0, 32'd0, 32'd0, 0, 0, got);
        check32("after_clear", got, 32'h0000_0000);

        // timeout: CFU never answers
        run_op({7'd8, 3'd0}, 32'd5, 32'd6, 32'd0, 0, 2, got);
        check32("timeout_word", got, 32'hDEAD_BEEF);
        run_op({7'd0, 3'b111}, 32'd0, 32'd0, 32'd0, 0, 0, got);
        check32("timeout_status", got, 32'h0001_0000);

        // valid on the very cycle the timeout would fire
        run_op({7'd9, 3'd4}, 32'd7, 32'd8, 32'h0000_55AA, TO, 0, got);
        check32("edge_valid_data", got, 32'h0000_55AA);
        run_op({7'd5, 3'b111}, 32'd0, 32'd0, 32'd0, 0, 0, got);
        check32("edge_status", got, 32'h0001_0001);
        run_op({7'd1, 3'b111}, 32'd0, 32'd0, 32'd0, 0, 0, got);
        check32("clear2_ret", got, 32'h0001_0001);

        // saturation from 16'hFFFE
        force dut.u_op_cnt.r_q = 16'hFFFE;
        step();
        release dut.u_op_cnt.r_q;
        m_ops = 32'd65534;
        step();
        for (int i = 0; i < 3; i++)
            run_op({7'd2, 3'd0}, i, i + 1, 32'h100 + i, 1, 0, got);
        run_op({7'd0, 3'b111}, 32'd0, 32'd0, 32'd0, 0, 0, got);
        check32("sat_status", got, 32'h0000_FFFF);

        // reset in the middle of WAIT
        exp_idle();
        cmd_valid = 1'b1;
        cmd_payload_function_id = {7'd3, 3'd2};
        cmd_payload_inputs_0 = 32'hA5A5_0001;
        cmd_payload_inputs_1 = 32'hA5A5_0002;
        step();
        cmd_valid = 1'b0;
        e_cmd = 7'd3; e_inp0 = 32'hA5A5_0001; e_inp1 = 32'hA5A5_0002;
        e_cmd_ready = 1'b0; e_busy = 1'b1; e_cfu_en = 1'b1;
        step();
        e_cfu_en = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        e_cmd_ready = 1'b0; e_busy = 1'b0; e_cfu_en = 1'b0; e_rsp_valid = 1'b0;
        e_cmd = 7'd0; e_inp0 = 32'd0; e_inp1 = 32'd0;
        m_ops = 0; m_tos = 0;
        #1;
        check1("arst_cmd_ready", cmd_ready, 1'b0);
        check1("arst_busy", busy, 1'b0);
        check1("arst_cfu_en", cfu_en, 1'b0);
        check1("arst_rsp_valid", rsp_valid, 1'b0);
        check32("arst_cfu_cmd", {25'd0, cfu_cmd}, 32'd0);
        check32("arst_inp0", cfu_inp0, 32'd0);
        check32("arst_inp1", cfu_inp1, 32'd0);
        check32("arst_rsp_data", rsp_payload_outputs_0, 32'd0);
        step();
        step();
        #1;
        reset_n = 1'b1;
        exp_idle();
        step();
        step();
        step();
        run_op({7'd0, 3'b111}, 32'd0, 32'd0, 32'd0, 0, 0, got);
        check32("post_reset_status", got, 32'h0000_0000);
        step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
